param_nco: RTL
==============

# param_nco

Parametrised, pipelined numerically controlled oscillator producing quadrature sine/cosine samples for the modulator and demodulator datapaths (carrier generation for MSK/FSK/PSK mixing). It supersedes the fixed 32-bit/10-bit NCO with generic accumulator, phase and output widths, and a quarter-wave lookup table. It also adds registered phase-increment loading with acknowledge, phase modulation, and phase synchronisation.

## Interface
- ACC_W, 32: phase accumulator width, bits.
- PHASE_W, 12: truncated phase width addressing the waveform, ≥ 4. The quarter-wave table has 2^(PHASE_W-2) entries.
- OUT_W, 10: signed two's-complement output width, ≤ 18.

- clk  in  1  clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- clken  in  1  pipeline enable. An edge with clken=1 is an "enabled edge".
- phi_inc_i  in  ACC_W  phase increment, loaded only on cfg_load_i.
- cfg_load_i  in  1  load strobe for phi_inc_i.
- cfg_ack_o  out  1  one-cycle pulse confirming a load.
- freq_mod_i  in  ACC_W  per-sample frequency offset, added every enabled edge.
- phase_mod_i  in  ACC_W  per-sample phase offset, added after the accumulator.
- sync_i  in  1  clears the accumulator on an enabled edge.
- fsin_o  out  OUT_W  signed sine sample.
- fcos_o  out  OUT_W  signed cosine sample.
- out_valid  out  1  fsin_o/fcos_o hold a new sample.

## Operation
- **Increment register (inc_r).**
  - Any edge with cfg_load_i=1 loads inc_r <= phi_inc_i, independent of clken.
  - cfg_ack_o is 1 on the following cycle only.
  - Back-to-back loads produce back-to-back acks; the last value wins.
  - The new increment takes effect from the first enabled edge after the load edge.
- **Stage 0 (accumulator), on each enabled edge:**
  - acc <= sync_i ? 0 : acc + inc_r + freq_mod_i, modulo 2^ACC_W (natural wrap, no saturation).
  - sync_i has priority over the increment.
- **Stage 1, on each enabled edge:** ph <= (acc + phase_mod_i)[ACC_W-1 : ACC_W-PHASE_W]. acc here is the value before this edge.
- **Stage 2, on each enabled edge:**
  - Quadrant q = ph[PHASE_W-1:PHASE_W-2]; address a = ph[PHASE_W-3:0]; mirrored address ~a.
  - Two ROM reads are registered with q.
  - Sine reads lut[a], lut[~a], lut[a], lut[~a] for q = 0..3.
  - Cosine reads lut[~a], lut[a], lut[~a], lut[a] for q = 0..3.
- **Stage 3, on each enabled edge:** apply sign, then register to outputs.
  - Sine is negative for q = 2, 3.
  - Cosine is negative for q = 1, 2.
  - Negation is two's complement; -0 = 0.
- **Table contents.** lut[k] = round((2^(OUT_W-1)-1) * sin(2π(k+0.5)/2^PHASE_W)), generated at elaboration.
  - The half-LSB offset gives exact quadrant symmetry.
  - Output range is symmetric, ±(2^(OUT_W-1)-1). The value -2^(OUT_W-1) never occurs.
- **Valid tracking.** A 2-bit fill register is cleared by reset and shifts in 1 on each enabled edge.

## Timing
- **Reset values.** acc, inc_r, ph, table registers, fill register: 0. fsin_o = 0, fcos_o = 0, out_valid = 0, cfg_ack_o = 0.
- **Latency.** 3 enabled edges from an accumulator value to the corresponding output. The first sample after reset release (phase 0) appears on the 3rd enabled edge.
- **out_valid, enabled edge:** out_valid <= fill[1].
- **out_valid, non-enabled edge:** out_valid <= 0. All other pipeline registers and outputs hold.
- **sync_i on enabled edge n:** the phase-0 sample (plus phase_mod_i) is output at enabled edge n+3. Samples already in flight complete normally.
- **clken low mid-stream:** no sample is lost or duplicated. The output sequence resumes exactly where it paused.
- **Reset asserted mid-operation:** all state returns to reset values on that edge, including inc_r. Software reloads the increment afterwards.
- **cfg_load_i with clken low:** the load still completes and is acknowledged. The accumulator does not advance until clken returns.

## Configuration
- **NCO_DITHER_EN defined:**
  - A 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1 on reset) advances on each enabled edge.
  - Its low min(16, ACC_W-PHASE_W) bits are added to acc + phase_mod_i before truncation in stage 1. This spreads truncation spurs.
  - Latency is unchanged.
- **NCO_DITHER_EN undefined:** no LFSR is built, and the output is the exact deterministic table lookup. All test values below assume it is undefined.

## Test plan
- **Quarter-rate tone.** Reset, load phi_inc_i=2^30, freq_mod_i=0, phase_mod_i=0, clken=1.
  - cfg_ack_o pulses once.
  - After latency, fsin_o repeats 0, 511, 0, -511 and fcos_o repeats 511, 0, -511, 0 (defaults), with out_valid=1.
- **Phase modulation.** Same tone with phase_mod_i=2^30 → fsin_o sequence shifted one sample earlier (511, 0, -511, 0).
- **Sync.** Mid-stream pulse sync_i for one enabled edge → fsin_o=0, fcos_o=511 on the 3rd enabled edge after it, then the sequence continues.
- **clken gaps.** Hold clken=0 for 5 cycles mid-stream.
  - out_valid=0 and outputs frozen during the gap.
  - Concatenating valid samples gives an unbroken 0, 511, 0, -511 sequence.
- **Frequency modulation and wrap.** Load phi_inc_i=2^31, freq_mod_i=2^30 → per-sample phase advance 3/4 cycle. fsin_o repeats 0, -511, 0, 511 across the accumulator wrap.
- **Reset mid-operation.** Assert reset_n=0 for one edge while streaming → all outputs 0, out_valid=0, inc_r=0. Without a reload, the outputs afterwards are the constant phase-0 sample (0, 511).

Source files
------------

// File: rtl/param_nco_if.sv
// -----------------------------------------------------------------------------
// param_nco_if
//
// Purpose : bundles the control, modulation and sample signals of param_nco so
//           that the oscillator and its controller connect through one port.
//           Clock and reset stay plain ports on the modules.
//
// Parameters
//   ACC_W  phase accumulator / increment / modulation width (must match the NCO)
//   OUT_W  signed sample width (must match the NCO)
//
// Signals (direction seen from the NCO, i.e. the slave modport)
//   clken        in   pipeline enable; an edge with clken=1 is an enabled edge
//   phi_inc_i    in   phase increment, captured only when cfg_load_i=1
//   cfg_load_i   in   load strobe for phi_inc_i
//   cfg_ack_o    out  one-cycle pulse confirming a load
//   freq_mod_i   in   per-sample frequency offset added to the accumulator
//   phase_mod_i  in   per-sample phase offset added after the accumulator
//   sync_i       in   clears the accumulator on an enabled edge
//   fsin_o       out  signed sine sample
//   fcos_o       out  signed cosine sample
//   out_valid    out  fsin_o/fcos_o carry a new sample this cycle
// -----------------------------------------------------------------------------
interface param_nco_if #(
  parameter int ACC_W = 32,
  parameter int OUT_W = 10
);
  logic                    clken;
  logic [ACC_W-1:0]        phi_inc_i;
  logic                    cfg_load_i;
  logic                    cfg_ack_o;
  logic [ACC_W-1:0]        freq_mod_i;
  logic [ACC_W-1:0]        phase_mod_i;
  logic                    sync_i;
  logic signed [OUT_W-1:0] fsin_o;
  logic signed [OUT_W-1:0] fcos_o;
  logic                    out_valid;

  // Controller side: drives configuration and modulation, receives samples.
  modport master (
    output clken, phi_inc_i, cfg_load_i, freq_mod_i, phase_mod_i, sync_i,
    input  cfg_ack_o, fsin_o, fcos_o, out_valid
  );

  // Oscillator side.
  modport slave (
    input  clken, phi_inc_i, cfg_load_i, freq_mod_i, phase_mod_i, sync_i,
    output cfg_ack_o, fsin_o, fcos_o, out_valid
  );
endinterface

// File: rtl/param_nco.sv
// -----------------------------------------------------------------------------
// param_nco
//
// Purpose : pipelined numerically controlled oscillator producing quadrature
//           sine/cosine carrier samples for the modem mixers. A phase
//           accumulator is truncated to PHASE_W bits, the top two bits select
//           the quadrant and the rest address a quarter-wave table; symmetry
//           (address mirroring + sign) rebuilds the full wave.
//
// Parameters
//   ACC_W    phase accumulator width (default 32)
//   PHASE_W  truncated phase width, >= 4; table has 2^(PHASE_W-2) entries
//   OUT_W    signed output width, <= 18; range is +/-(2^(OUT_W-1)-1)
//
// Ports
//   clk      rising-edge clock for all logic
//   reset_n  synchronous, active-low reset (clears everything, including the
//            increment register)
//   bus      param_nco_if.slave: clken, phi_inc_i/cfg_load_i/cfg_ack_o,
//            freq_mod_i, phase_mod_i, sync_i, fsin_o/fcos_o/out_valid
//
// Pipeline (all stages advance only on enabled edges)
//   stage 0  acc   <= sync ? 0 : acc + inc + freq_mod
//   stage 1  ph    <= top PHASE_W bits of (acc + phase_mod [+ dither])
//   stage 2  table reads for sine and cosine, registered with the quadrant
//   stage 3  sign applied, registered onto fsin_o/fcos_o
//   An accumulator value reaches the outputs 3 enabled edges later.
//
// Build option
//   NCO_DITHER_EN  when defined, a 16-bit Fibonacci LFSR
//                  (x^16+x^14+x^13+x^11+1, seed 16'hACE1) adds its low
//                  min(16, ACC_W-PHASE_W) bits below the truncation point in
//                  stage 1 to spread truncation spurs. Latency is unchanged.
//                  When undefined the output is the exact table lookup.
// -----------------------------------------------------------------------------
module param_nco #(
  parameter int ACC_W   = 32,
  parameter int PHASE_W = 12,
  parameter int OUT_W   = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  param_nco_if.slave  bus
);

  localparam int  ADDR_W = PHASE_W - 2;        // quarter-wave address width
  localparam int  LUT_N  = 1 << ADDR_W;        // quarter-wave table depth
  localparam int  MAG_W  = OUT_W - 1;          // unsigned magnitude width
  localparam int  AMP    = (1 << MAG_W) - 1;   // peak amplitude
  localparam real TWO_PI = 6.283185307179586;

  // ---------------------------------------------------------------------------
  // Quarter-wave table, computed at elaboration. The half-LSB phase offset
  // places samples symmetrically about every quadrant boundary, so mirroring
  // the address (~a) reproduces the next quadrant exactly and no sample ever
  // lands on a zero crossing or a peak shared between quadrants.
  // ---------------------------------------------------------------------------
  function automatic int lut_entry(input int k);
    real theta;
    real v;
    theta = TWO_PI * (real'(k) + 0.5) / real'(LUT_N * 4);
    v     = real'(AMP) * $sin(theta);
    // First-quadrant values are non-negative, so +0.5 and truncate rounds.
    return $rtoi(v + 0.5);
  endfunction

  logic [MAG_W-1:0] lut [LUT_N];

  for (genvar gi = 0; gi < LUT_N; gi++) begin : g_lut
    localparam logic [MAG_W-1:0] ENTRY = MAG_W'(lut_entry(gi));
    assign lut[gi] = ENTRY;
  end

  // ---------------------------------------------------------------------------
  // Increment register. Loads on any edge with cfg_load_i, regardless of
  // clken, so software can reprogram while the pipeline is stalled. The ack
  // simply mirrors the strobe one cycle later, which makes back-to-back loads
  // produce back-to-back acks.
  // ---------------------------------------------------------------------------
  logic [ACC_W-1:0] inc_reg;
  logic             ack_reg;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      inc_reg <= '0;
      ack_reg <= 1'b0;
    end else begin
      ack_reg <= bus.cfg_load_i;
      if (bus.cfg_load_i) begin
        inc_reg <= bus.phi_inc_i;
      end
    end
  end

  assign bus.cfg_ack_o = ack_reg;

  // ---------------------------------------------------------------------------
  // Optional phase dither source.
  // ---------------------------------------------------------------------------
  logic [ACC_W-1:0] dither_ext;

`ifdef NCO_DITHER_EN
  localparam int DITHER_W = (ACC_W - PHASE_W < 16) ? (ACC_W - PHASE_W) : 16;

  logic [15:0] lfsr_reg;
  logic [15:0] lfsr_next;
  logic        lfsr_fb;

  // Fibonacci form: taps 16,14,13,11 map to bits 15,13,12,10.
  assign lfsr_fb   = lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10];
  assign lfsr_next = {lfsr_reg[14:0], lfsr_fb};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lfsr_reg <= 16'hACE1;
    end else if (bus.clken) begin
      lfsr_reg <= lfsr_next;
    end
  end

  if (DITHER_W > 0) begin : g_dither
    assign dither_ext = ACC_W'(lfsr_reg[DITHER_W-1:0]);
  end else begin : g_no_dither
    // No bits below the truncation point: dither has nothing to act on.
    assign dither_ext = '0;
  end
`else
  assign dither_ext = '0;
`endif

  // ---------------------------------------------------------------------------
  // Stage 0 (accumulator) and stage 1 (phase offset + truncation).
  // Stage 1 deliberately uses the accumulator value from before this edge.
  // ---------------------------------------------------------------------------
  logic [ACC_W-1:0]   acc_reg;
  logic [ACC_W-1:0]   acc_next;
  logic [ACC_W-1:0]   ph_sum;
  logic [PHASE_W-1:0] ph_reg;
  logic [PHASE_W-1:0] ph_next;

  // sync_i wins over the increment; the sum wraps modulo 2^ACC_W.
  assign acc_next = bus.sync_i ? '0 : (acc_reg + inc_reg + bus.freq_mod_i);
  assign ph_sum   = acc_reg + bus.phase_mod_i + dither_ext;
  assign ph_next  = ph_sum[ACC_W-1 -: PHASE_W];

  if (ACC_W > PHASE_W) begin : g_trunc
    // Fractional phase bits are discarded by design.
    logic unused_frac;
    assign unused_frac = ^ph_sum[ACC_W-PHASE_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc_reg <= '0;
      ph_reg  <= '0;
    end else if (bus.clken) begin
      acc_reg <= acc_next;
      ph_reg  <= ph_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: quadrant decode and table reads.
  // Odd quadrants walk the quarter wave backwards for sine and forwards for
  // cosine, so one mirrored address serves both channels.
  // ---------------------------------------------------------------------------
  logic [1:0]        quad;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] addr_mir;
  logic [ADDR_W-1:0] sin_addr;
  logic [ADDR_W-1:0] cos_addr;

  assign quad     = ph_reg[PHASE_W-1 -: 2];
  assign addr     = ph_reg[ADDR_W-1:0];
  assign addr_mir = ~addr;
  assign sin_addr = quad[0] ? addr_mir : addr;
  assign cos_addr = quad[0] ? addr     : addr_mir;

  logic [MAG_W-1:0] sin_mag_reg;
  logic [MAG_W-1:0] cos_mag_reg;
  logic [1:0]       quad_reg;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sin_mag_reg <= '0;
      cos_mag_reg <= '0;
      quad_reg    <= '0;
    end else if (bus.clken) begin
      sin_mag_reg <= lut[sin_addr];
      cos_mag_reg <= lut[cos_addr];
      quad_reg    <= quad;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: sign. Sine is negative in quadrants 2,3; cosine in 1,2.
  // A zero magnitude negates to zero, so -0 never appears, and the magnitude
  // never exceeds AMP, so the most negative code is never produced.
  // ---------------------------------------------------------------------------
  logic             sin_neg;
  logic             cos_neg;
  logic [OUT_W-1:0] sin_ext;
  logic [OUT_W-1:0] cos_ext;
  logic [OUT_W-1:0] sin_next;
  logic [OUT_W-1:0] cos_next;

  assign sin_neg  = quad_reg[1];
  assign cos_neg  = quad_reg[1] ^ quad_reg[0];
  assign sin_ext  = {1'b0, sin_mag_reg};
  assign cos_ext  = {1'b0, cos_mag_reg};
  assign sin_next = sin_neg ? (~sin_ext + OUT_W'(1)) : sin_ext;
  assign cos_next = cos_neg ? (~cos_ext + OUT_W'(1)) : cos_ext;

  logic signed [OUT_W-1:0] fsin_reg;
  logic signed [OUT_W-1:0] fcos_reg;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fsin_reg <= '0;
      fcos_reg <= '0;
    end else if (bus.clken) begin
      fsin_reg <= sin_next;
      fcos_reg <= cos_next;
    end
  end

  assign bus.fsin_o = fsin_reg;
  assign bus.fcos_o = fcos_reg;

  // ---------------------------------------------------------------------------
  // Valid tracking. The fill register marks how many enabled edges have
  // passed since reset; once two have, stage 3 holds real data. out_valid is
  // forced low on stalled edges so each sample is flagged exactly once.
  // ---------------------------------------------------------------------------
  logic [1:0] fill_reg;
  logic       valid_reg;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fill_reg  <= 2'b00;
      valid_reg <= 1'b0;
    end else if (bus.clken) begin
      fill_reg  <= {fill_reg[0], 1'b1};
      valid_reg <= fill_reg[1];
    end else begin
      valid_reg <= 1'b0;
    end
  end

  assign bus.out_valid = valid_reg;

endmodule
